serial_adder: RTL



---
 rtl/serial_adder.sv | 101 ++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder/subtractor, one full-adder slice with registered carry, LSB first
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             bit_s, carry_nxt, accept, last_bit;

    always_comb begin
        bit_s     = a_sr[0] ^ b_sr[0] ^ carry;
        carry_nxt = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
        last_bit  = (state == RUN) && (cnt == LAST);
        // start is honoured in IDLE and DONE, never while bits are in flight
        accept    = start && (state != RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b ^ {WIDTH{sub}};
            carry  <= cin ^ sub;
            res_sr <= '0;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= {bit_s, res_sr[WIDTH-1:1]};
            carry  <= carry_nxt;
            cnt    <= cnt + 1'b1;
            if (last_bit) begin
                // carry still holds the carry into the MSB on the final bit
                sum  <= {bit_s, res_sr[WIDTH-1:1]};
                cout <= carry_nxt;
                ovf  <= carry ^ carry_nxt;
            end
        end
    end

endmodule
